// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multicycle control sequencer.
package kgp_ctrl_pkg;

    localparam int unsigned PC_W_DEF  = 8;
    localparam int unsigned RET_W_DEF = 16;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned FN_W      = 4;
    localparam int unsigned WB_SEL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcode classes
    localparam logic [OP_W-1:0] OP_ALU_RR  = 2'b00;
    localparam logic [OP_W-1:0] OP_ALU_IMM = 2'b01;
    localparam logic [OP_W-1:0] OP_MEM     = 2'b10;
    localparam logic [OP_W-1:0] OP_CTRL    = 2'b11;

    // Branch/control function codes (op == OP_CTRL)
    localparam logic [FN_W-1:0] FN_BR   = 4'b0000;
    localparam logic [FN_W-1:0] FN_BLTZ = 4'b0001;
    localparam logic [FN_W-1:0] FN_BZ   = 4'b0010;
    localparam logic [FN_W-1:0] FN_BNZ  = 4'b0011;
    localparam logic [FN_W-1:0] FN_BL   = 4'b0100;
    localparam logic [FN_W-1:0] FN_BCY  = 4'b0101;
    localparam logic [FN_W-1:0] FN_BNCY = 4'b0110;
    localparam logic [FN_W-1:0] FN_JR   = 4'b0111;
    localparam logic [FN_W-1:0] FN_HALT = 4'b1111;

    // Writeback source select
    localparam logic [WB_SEL_W-1:0] WB_ALU  = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_MEM  = 2'b01;
    localparam logic [WB_SEL_W-1:0] WB_LINK = 2'b10;

    // Memory ops: fn[0] distinguishes sw from lw
    function automatic logic is_store(input logic [FN_W-1:0] fn_in);
        return fn_in[0];
    endfunction

endpackage

// File: rtl/kgp_branch_eval.sv
// Decodes branch/control function codes and evaluates the branch condition.
module kgp_branch_eval
    import kgp_ctrl_pkg::*;
(
    input  logic [FN_W-1:0] fn,
    input  logic            rs_is_zero,
    input  logic            rs_is_neg,
    input  logic            carry,
    output logic            take,
    output logic            is_jr,
    output logic            is_halt,
    output logic            is_link
);

    // Unlisted function codes fall through as NOPs (take=0, no flags)
    always_comb begin
        take    = 1'b0;
        is_jr   = 1'b0;
        is_halt = 1'b0;
        is_link = 1'b0;
        case (fn)
            FN_BR:   take = 1'b1;
            FN_BLTZ: take = rs_is_neg;
            FN_BZ:   take = rs_is_zero;
            FN_BNZ:  take = !rs_is_zero;
            FN_BL: begin
                take    = 1'b1;
                is_link = 1'b1;
            end
            FN_BCY:  take = carry;
            FN_BNCY: take = !carry;
            FN_JR:   is_jr = 1'b1;
            FN_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the PC, drives datapath
// strobes, resolves branches and counts retired instructions.
module kgp_control_fsm
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned RET_W = RET_W_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imem_ready,
    input  logic [OP_W-1:0]     op,
    input  logic [FN_W-1:0]     fn,
    input  logic [PC_W-1:0]     addr,
    input  logic [PC_W-1:0]     rs_val,
    input  logic                rs_is_zero,
    input  logic                rs_is_neg,
    input  logic                alu_carry,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_load,
    output logic                alu_en,
    output logic                alu_src_imm,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write,
    output logic [WB_SEL_W-1:0] wb_sel,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic [RET_W-1:0]    retired,
    output logic [STATE_W-1:0]  state
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [PC_W-1:0]      w_pc_inc;
    logic                 r_carry;
    logic                 w_carry_nxt;
    logic [RET_W-1:0]     r_retired;
    logic                 w_retire;
    logic                 r_halted;
    logic                 w_halted_nxt;
    logic                 r_alu_en;
    logic                 w_alu_en_nxt;
    logic                 r_alu_src_imm;
    logic                 w_alu_src_imm_nxt;
    logic                 r_dmem_req;
    logic                 w_dmem_req_nxt;
    logic                 r_dmem_we;
    logic                 w_dmem_we_nxt;
    logic                 r_reg_write;
    logic                 w_reg_write_nxt;
    logic [WB_SEL_W-1:0]  r_wb_sel;
    logic [WB_SEL_W-1:0]  w_wb_sel_nxt;
    logic                 w_take;
    logic                 w_is_jr;
    logic                 w_is_halt;
    logic                 w_is_link;

    kgp_branch_eval u_branch_eval (
        .fn         (fn),
        .rs_is_zero (rs_is_zero),
        .rs_is_neg  (rs_is_neg),
        .carry      (r_carry),
        .take       (w_take),
        .is_jr      (w_is_jr),
        .is_halt    (w_is_halt),
        .is_link    (w_is_link)
    );

    assign w_pc_inc = r_pc + PC_W'(1);

    // Fetch handshake is decoded from the state so ir_load lands in the ready cycle
    assign imem_req = (r_state == ST_FETCH);
    assign ir_load  = (r_state == ST_FETCH) && imem_ready;

    // Next state plus the strobe values the next state will present
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_carry_nxt       = r_carry;
        w_retire          = 1'b0;
        w_halted_nxt      = r_halted;
        w_alu_en_nxt      = 1'b0;
        w_alu_src_imm_nxt = 1'b0;
        w_dmem_req_nxt    = 1'b0;
        w_dmem_we_nxt     = 1'b0;
        w_reg_write_nxt   = 1'b0;
        w_wb_sel_nxt      = WB_ALU;

        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_state_nxt = ST_EXEC;
                case (op)
                    OP_ALU_RR: w_alu_en_nxt = 1'b1;
                    OP_ALU_IMM, OP_MEM: begin
                        w_alu_en_nxt      = 1'b1;
                        w_alu_src_imm_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_EXEC: begin
                case (op)
                    OP_ALU_RR, OP_ALU_IMM: begin
                        w_carry_nxt     = alu_carry;
                        w_state_nxt     = ST_WB;
                        w_reg_write_nxt = 1'b1;
                        w_wb_sel_nxt    = WB_ALU;
                    end
                    OP_MEM: begin
                        w_state_nxt    = ST_MEM;
                        w_dmem_req_nxt = 1'b1;
                        w_dmem_we_nxt  = is_store(fn);
                    end
                    default: begin
                        if (w_is_halt) begin
                            w_state_nxt  = ST_HALT;
                            w_halted_nxt = 1'b1;
                        end else if (w_is_link) begin
                            // bl keeps the old pc through WB so the link value is pc+1
                            w_state_nxt     = ST_WB;
                            w_reg_write_nxt = 1'b1;
                            w_wb_sel_nxt    = WB_LINK;
                        end else begin
                            w_state_nxt = ST_FETCH;
                            w_retire    = 1'b1;
                            if (w_is_jr) begin
                                w_pc_nxt = rs_val;
                            end else if (w_take) begin
                                w_pc_nxt = addr;
                            end else begin
                                w_pc_nxt = w_pc_inc;
                            end
                        end
                    end
                endcase
            end

            ST_MEM: begin
                if (dmem_ready) begin
                    if (is_store(fn)) begin
                        w_state_nxt = ST_FETCH;
                        w_retire    = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end else begin
                        w_state_nxt     = ST_WB;
                        w_reg_write_nxt = 1'b1;
                        w_wb_sel_nxt    = WB_MEM;
                    end
                end else begin
                    w_dmem_req_nxt = 1'b1;
                    w_dmem_we_nxt  = is_store(fn);
                end
            end

            ST_WB: begin
                w_state_nxt = ST_FETCH;
                w_retire    = 1'b1;
                w_pc_nxt    = (r_wb_sel == WB_LINK) ? addr : w_pc_inc;
            end

            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // State, architectural registers and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= '0;
            r_carry       <= 1'b0;
            r_retired     <= '0;
            r_halted      <= 1'b0;
            r_alu_en      <= 1'b0;
            r_alu_src_imm <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_wb_sel      <= WB_ALU;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_carry       <= w_carry_nxt;
            r_retired     <= r_retired + RET_W'(w_retire);
            r_halted      <= w_halted_nxt;
            r_alu_en      <= w_alu_en_nxt;
            r_alu_src_imm <= w_alu_src_imm_nxt;
            r_dmem_req    <= w_dmem_req_nxt;
            r_dmem_we     <= w_dmem_we_nxt;
            r_reg_write   <= w_reg_write_nxt;
            r_wb_sel      <= w_wb_sel_nxt;
        end
    end

    assign alu_en      = r_alu_en;
    assign alu_src_imm = r_alu_src_imm;
    assign dmem_req    = r_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign reg_write   = r_reg_write;
    assign wb_sel      = r_wb_sel;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign retired     = r_retired;
    assign state       = STATE_W'(r_state);

endmodule

// File: doc/kgp_control_fsm.md
Name: kgp_control_fsm

Overview:
Multicycle control sequencer for the KGP-RISC core.
- Owns the 8-bit program counter.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives enable strobes for the instruction memory, register file, ALU and data memory.
- Resolves branches and counts retired instructions.
- Sits between the instruction decoder (op/fn fields) and the datapath; its `pc` output feeds the existing line-number display.

Parameters:
- PC_W, 8, program counter / branch address width.
- RET_W, 16, retired-instruction counter width.

Ports:
- clk  input  1  system clock. One clock domain, rising edge.
- rst_n  input  1  reset. Synchronous, active-low.
- imem_ready  input  1  instruction word valid this cycle.
- op  input  2  opcode field of the current instruction register.
- fn  input  4  function field.
- addr  input  PC_W  branch target field.
- rs_val  input  PC_W  low bits of rs, used as the jr target.
- rs_is_zero  input  1  rs == 0.
- rs_is_neg  input  1  rs[31].
- alu_carry  input  1  ALU carry-out.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instruction register.
- alu_en  output  1  ALU evaluate/latch result.
- alu_src_imm  output  1  ALU B operand = immediate.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write.
- reg_write  output  1  register file write.
- wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 pc+1 (link).
- pc  output  PC_W  current instruction address.
- halted  output  1  processor halted.
- retired  output  RET_W  retired-instruction count.
- state  output  3  FSM state, for debug.

Behaviour:
Reset (rst_n low at a clock edge):
- state=FETCH; pc=0; carry flag=0; retired=0; halted=0.
- All strobes 0; wb_sel=00.
- Reset mid-operation drops any pending imem_req or dmem_req the same edge; no partial writeback.

Opcode classes:
- op=00: ALU reg-reg.
- op=01: ALU immediate.
- op=10: memory. fn[0]=0 is lw, 1 is sw.
- op=11: branch/control. fn: 0000 br, 0001 bltz, 0010 bz, 0011 bnz, 0100 bl, 0101 bcy, 0110 bncy, 0111 jr, 1111 halt.
- Any other op=11 fn is a NOP: retires in EXEC with pc+1.

States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1. Hold the state while imem_ready=0. On imem_ready=1, ir_load=1 for one cycle and go to DECODE.
- DECODE: one cycle, register file read. Always go to EXEC.
- EXEC:
  - ALU ops: alu_en=1, alu_src_imm=(op==01). Carry flag <= alu_carry. Go to WB.
  - Memory ops: alu_en=1, alu_src_imm=1 (address calculation). Go to MEM.
  - Branches: evaluate the condition, update pc, retire, go to FETCH.
  - bl: go to WB instead of FETCH.
  - halt: go to HALT, halted=1.
- MEM: dmem_req=1 and dmem_we=sw, held until dmem_ready.
  - lw: go to WB.
  - sw: retire in the dmem_ready cycle, go to FETCH.
- WB: reg_write=1 for exactly one cycle. wb_sel = 00 (ALU), 01 (lw) or 10 (bl). Retire, go to FETCH.
- HALT: absorbing state; all strobes 0. Left only by reset.

Branch conditions:
- bltz: rs_is_neg. bz: rs_is_zero. bnz: !rs_is_zero.
- bcy: carry flag. bncy: !carry flag.
- br, bl: unconditional.

Next-PC rules:
- Taken br/bl/conditional branch: pc <= addr.
- jr: pc <= rs_val.
- Otherwise: pc <= pc+1, wrapping 8'hFF to 8'h00.
- bl: pc is updated in WB, so the link value pc+1 is taken from the pre-update pc.

Retire:
- retired increments by 1 in each retire cycle and wraps at 2^RET_W.
- halt does not count as retired.

Latency with zero memory wait (cycles from FETCH entry to next FETCH):
- ALU: 4. lw: 5. sw: 4. branch/jr/NOP: 3. bl: 4.
- Each wait cycle on imem_ready or dmem_ready adds one cycle.

Strobe exclusivity:
- At most one of ir_load, alu_en, dmem_req, reg_write is high in any cycle.

Decomposition:
- Package kgp_ctrl_pkg:
  - state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5).
  - opcode constants.
  - branch fn codes.
  - wb_sel encodings.
- Sub-module kgp_branch_eval: combinational. Inputs fn, rs_is_zero, rs_is_neg, carry. Outputs take, is_jr, is_halt, is_link.

Test Plan:
1. Reset, then an add (op=00) with imem_ready tied 1 → ir_load at cycle 1, alu_en at 3, reg_write at 4 with wb_sel=00; pc 0→1; retired=1.
2. lw with dmem_ready delayed 3 cycles → dmem_req high 4 cycles; reg_write with wb_sel=01 one cycle after ready; total 8 cycles; pc+1.
3. ALU op with alu_carry=1, then bcy addr=8'h40 → pc=8'h40. Repeat with carry=0 → pc+1.
4. bl addr=8'h10 at pc=8'h05 → WB cycle has reg_write=1, wb_sel=10; then pc=8'h10. jr with rs_val=8'h22 → pc=8'h22 after 3 cycles.
5. Instruction retired at pc=8'hFF → pc=8'h00. halt → halted=1, strobes stay 0 for 20 cycles, pc and retired frozen.
6. rst_n low during MEM with dmem_req=1 → next cycle dmem_req=0, state=FETCH, pc=0, retired=0, no reg_write.
